// File: rtl/ddf_flux_scheduler.sv
// Round-robin scheduler that buffers tagged tokens per flux and issues them to
// one shared downstream actor port in bounded bursts under backpressure.
module ddf_flux_scheduler #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4,
  parameter int BURST      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_port_write,
  input  logic [WIDTH-1:0]     in_port_datain,
  output logic [FLUX-1:0]      in_port_full,
  output logic                 out_port_write,
  output logic [WIDTH-1:0]     out_port_dataout,
  input  logic                 out_port_full,
  output logic [TAG_WIDTH-1:0] grant,
  output logic                 busy,
  output logic                 drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [FLUX][DEPTH];
  logic [PW-1:0]         rd_ptr [FLUX];
  logic [PW-1:0]         wr_ptr [FLUX];
  logic [CW-1:0]         count [FLUX];
  logic [CW-1:0]         count_nxt [FLUX];
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [BW-1:0]         bcnt;

  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  push_ok, serve_pop, do_arb, arb_found;
  logic [FLUX-1:0]       push, pop, nonempty, nonempty_nxt;
  logic [TAG_WIDTH-1:0]  idle_grant, arb_grant;

  function automatic logic [TAG_WIDTH-1:0] wrap(input int v);
    return TAG_WIDTH'(v % FLUX);
  endfunction

  assign in_tag    = in_port_datain[WIDTH-1 -: TAG_WIDTH];
  assign in_data   = in_port_datain[DATA_WIDTH-1:0];
  assign push_ok   = in_port_write && (int'(in_tag) < FLUX) && !in_port_full[in_tag];
  assign serve_pop = (state == SERVE) && !out_port_full && nonempty[grant];
  assign busy      = (state != IDLE);

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    push = '0;
    pop  = '0;
    if (push_ok)   push[in_tag] = 1'b1;
    if (serve_pop) pop[grant]   = 1'b1;
    for (int f = 0; f < FLUX; f++) begin
      count_nxt[f] = count[f];
      if (push[f] && !pop[f])      count_nxt[f] = count[f] + 1'b1;
      else if (pop[f] && !push[f]) count_nxt[f] = count[f] - 1'b1;
      nonempty[f]     = (count[f] != '0);
      nonempty_nxt[f] = (count_nxt[f] != '0);
      in_port_full[f] = (count[f] == CW'(DEPTH));
    end
  end

  // Descending scan so the lowest offset from the start point is assigned last and wins.
  always_comb begin
    idle_grant = grant;
    arb_grant  = grant;
    arb_found  = 1'b0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (nonempty[wrap(int'(rr_ptr) + 1 + i)])
        idle_grant = wrap(int'(rr_ptr) + 1 + i);
      if (nonempty_nxt[wrap(int'(grant) + 1 + i)]) begin
        arb_found = 1'b1;
        arb_grant = wrap(int'(grant) + 1 + i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    do_arb    = 1'b0;
    unique case (state)
      IDLE:  if (|nonempty) state_nxt = SERVE;
      SERVE: begin
        if (out_port_full) state_nxt = HOLD;
        else if (!serve_pop || bcnt == BW'(BURST - 1)) do_arb = 1'b1;
        if (do_arb && !arb_found) state_nxt = IDLE;
      end
      HOLD:  if (!out_port_full) state_nxt = SERVE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rr_ptr           <= TAG_WIDTH'(FLUX - 1);
      grant            <= '0;
      bcnt             <= '0;
      out_port_write   <= 1'b0;
      out_port_dataout <= '0;
      drop_err         <= 1'b0;
      for (int f = 0; f < FLUX; f++) begin
        rd_ptr[f] <= '0;
        wr_ptr[f] <= '0;
        count[f]  <= '0;
      end
    end else begin
      state          <= state_nxt;
      drop_err       <= in_port_write && !push_ok;
      out_port_write <= serve_pop;
      for (int f = 0; f < FLUX; f++) begin
        if (push[f]) wr_ptr[f] <= wr_ptr[f] + 1'b1;
        if (pop[f])  rd_ptr[f] <= rd_ptr[f] + 1'b1;
        count[f] <= count_nxt[f];
      end
      if (serve_pop) begin
        out_port_dataout <= {grant, mem[grant][rd_ptr[grant]]};
        bcnt             <= bcnt + 1'b1;
      end
      if (state == IDLE && |nonempty) begin
        grant <= idle_grant;
        bcnt  <= '0;
      end
      if (do_arb) begin
        rr_ptr <= grant;
        if (arb_found) begin
          grant <= arb_grant;
          bcnt  <= '0;
        end
      end
    end
  end

  // NOTE: buffer storage is not reset; the pointers and counts alone define
  // validity, so stale payloads are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[in_tag][wr_ptr[in_tag]] <= in_data;
  end

endmodule

// File: tb/tb_ddf_flux_scheduler.sv
// Self-checking bench for ddf_flux_scheduler: cycle-exact vector table for
// latency/fairness, scoreboard-checked sequences for the multi-cycle corners.
module tb_ddf_flux_scheduler;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_port_write = 1'b0;
  logic [W-1:0] in_port_datain = '0;
  logic [1:0]   in_port_full;
  logic         out_port_write;
  logic [W-1:0] out_port_dataout;
  logic         out_port_full = 1'b0;
  logic [0:0]   grant;
  logic         busy;
  logic         drop_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic         sb_en = 1'b0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] sb_exp;

  typedef struct {
    logic         wr;
    logic [W-1:0] din;
    logic         exp_ow;
    logic [W-1:0] exp_data;
    logic         exp_grant;
    logic         exp_busy;
  } vec_t;

  vec_t tbl [15];

  ddf_flux_scheduler #(
    .FLUX(2), .DATA_WIDTH(8), .DEPTH(4), .BURST(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_port_write(in_port_write),
    .in_port_datain(in_port_datain),
    .in_port_full(in_port_full),
    .out_port_write(out_port_write),
    .out_port_dataout(out_port_dataout),
    .out_port_full(out_port_full),
    .grant(grant),
    .busy(busy),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_tok(input logic [W-1:0] din);
    in_port_write  = 1'b1;
    in_port_datain = din;
    step();
    in_port_write  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("sb_drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: every issued token must be the next expected one.
  always @(negedge clk) begin
    if (sb_en && rst && out_port_write) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: actual %h required no token", out_port_dataout);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_token", 32'(out_port_dataout), 32'(sb_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    //            wr    din     ow    data    g     busy
    tbl[0]  = '{1'b1, 9'h104, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 9'h000, 1'b1, 9'h104, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 9'h001, 1'b0, 9'h000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 9'h002, 1'b0, 9'h000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 9'h003, 1'b1, 9'h001, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 9'h101, 1'b1, 9'h002, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 9'h102, 1'b1, 9'h101, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 9'h103, 1'b1, 9'h102, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 9'h000, 1'b1, 9'h003, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 9'h000, 1'b1, 9'h103, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0};

    // Reset held for 3 cycles.
    repeat (3) step();
    check("rst_ow",    32'(out_port_write),   32'd0);
    check("rst_data",  32'(out_port_dataout), 32'd0);
    check("rst_grant", 32'(grant),            32'd0);
    check("rst_busy",  32'(busy),             32'd0);
    check("rst_drop",  32'(drop_err),         32'd0);
    check("rst_full",  32'(in_port_full),     32'd0);
    rst = 1'b1;
    step();

    // Single-token latency, then fairness across two fluxes.
    for (int i = 0; i < 15; i++) begin
      in_port_write  = tbl[i].wr;
      in_port_datain = tbl[i].din;
      step();
      check($sformatf("tbl%0d_ow", i),    32'(out_port_write), 32'(tbl[i].exp_ow));
      check($sformatf("tbl%0d_grant", i), 32'(grant),          32'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_busy", i),  32'(busy),           32'(tbl[i].exp_busy));
      if (tbl[i].exp_ow)
        check($sformatf("tbl%0d_data", i), 32'(out_port_dataout), 32'(tbl[i].exp_data));
    end
    in_port_write = 1'b0;
    sb_en = 1'b1;

    // Backpressure for 4 cycles after the first token of a burst.
    sb_q.push_back(9'h011); write_tok(9'h011);
    sb_q.push_back(9'h012); write_tok(9'h012);
    sb_q.push_back(9'h013); write_tok(9'h013);
    out_port_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp%0d_ow", i),    32'(out_port_write), 32'd0);
      check($sformatf("bp%0d_grant", i), 32'(grant),          32'd0);
    end
    out_port_full = 1'b0;
    wait_drain(20);
    repeat (3) step();

    // Overflow of flux 0 while downstream is full.
    out_port_full = 1'b1;
    sb_q.push_back(9'h021); write_tok(9'h021);
    sb_q.push_back(9'h022); write_tok(9'h022);
    sb_q.push_back(9'h023); write_tok(9'h023);
    check("ovf_full_after3", 32'(in_port_full), 32'd0);
    sb_q.push_back(9'h024); write_tok(9'h024);
    check("ovf_full_after4", 32'(in_port_full), 32'd1);
    check("ovf_nodrop4",     32'(drop_err),     32'd0);
    write_tok(9'h025);
    check("ovf_drop5",       32'(drop_err),     32'd1);
    step();
    check("ovf_drop_pulse",  32'(drop_err),       32'd0);
    check("ovf_ow_held",     32'(out_port_write), 32'd0);
    out_port_full = 1'b0;
    step();
    check("ovf_resume_ow",   32'(out_port_write), 32'd0);
    check("ovf_full_held",   32'(in_port_full),   32'd1);
    step();
    check("ovf_first_ow",    32'(out_port_write), 32'd1);
    check("ovf_full_fall",   32'(in_port_full),   32'd0);
    wait_drain(20);
    repeat (3) step();

    // Flux 0 streamed while served; flux 1 still gets its turn.
    sb_q.push_back(9'h031); sb_q.push_back(9'h032); sb_q.push_back(9'h141);
    sb_q.push_back(9'h033); sb_q.push_back(9'h034); sb_q.push_back(9'h035);
    sb_q.push_back(9'h036);
    write_tok(9'h031);
    write_tok(9'h141);
    write_tok(9'h032);
    write_tok(9'h033);
    check("strm_grant1", 32'(grant), 32'd1);
    write_tok(9'h034);
    write_tok(9'h035);
    check("strm_grant0", 32'(grant), 32'd0);
    write_tok(9'h036);
    check("strm_notfull", 32'(in_port_full), 32'd0);
    wait_drain(20);
    repeat (3) step();

    // Reset with tokens buffered.
    out_port_full = 1'b1;
    write_tok(9'h151);
    write_tok(9'h152);
    write_tok(9'h153);
    check("mrst_pre_busy",  32'(busy),  32'd1);
    check("mrst_pre_grant", 32'(grant), 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_ow",    32'(out_port_write),   32'd0);
    check("mrst_data",  32'(out_port_dataout), 32'd0);
    check("mrst_grant", 32'(grant),            32'd0);
    check("mrst_busy",  32'(busy),             32'd0);
    check("mrst_full",  32'(in_port_full),     32'd0);
    repeat (2) step();
    rst = 1'b1;
    out_port_full = 1'b0;
    repeat (8) step();
    check("mrst_post_busy", 32'(busy), 32'd0);
    check("mrst_post_ow",   32'(out_port_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddf_flux_scheduler.md
# ddf_flux_scheduler

Round-robin scheduler that shares one downstream DDF actor port among FLUX tagged fluxes. Tagged tokens arrive on a single write port, are buffered per flux by tag, and are issued to the shared actor in bounded bursts under `out_port_full` backpressure. It sits between the producer FIFOs and a multi-flux actor such as PICK, so that no flux can starve another.

## Interface
- `FLUX`, 2: number of fluxes.
- `DATA_WIDTH`, 8: payload width.
- `TAG_WIDTH`, `$clog2(FLUX)` (minimum 1): flux tag width; the tag occupies the MSBs of the token.
- `WIDTH`, `DATA_WIDTH+TAG_WIDTH`: token width.
- `DEPTH`, 4: per-flux buffer depth; must be a power of 2 and ≥2.
- `BURST`, 2: maximum consecutive tokens issued per grant; ≥1.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_port_write`  in  1: token write strobe.
- `in_port_datain`  in  WIDTH: token, `{tag, payload}`.
- `in_port_full`  out  FLUX: bit f is high when the flux f buffer holds DEPTH tokens.
- `out_port_write`  out  1: registered; high for one cycle per issued token.
- `out_port_dataout`  out  WIDTH: registered; `{grant tag, payload}`.
- `out_port_full`  in  1: downstream backpressure.
- `grant`  out  TAG_WIDTH: flux currently being served.
- `busy`  out  1: high when the state is not IDLE.
- `drop_err`  out  1: one-cycle pulse when an input token is dropped.

## Operation
- Write path:
  - At an edge with `in_port_write`=1, the token's payload is pushed into buffer[tag].
  - The token is dropped instead, with `drop_err`=1 on the next cycle, if tag ≥ FLUX or buffer[tag] is full.
  - The tag is not stored; it is regenerated from `grant` on output.
- Each buffer has a read pointer, a write pointer and a count. A push and a pop on the same buffer at the same edge both take effect, and the count is unchanged.
- FSM states:
  - IDLE:
    - If any buffer is non-empty at the edge, `grant` is set to the first non-empty flux scanning upward from `rr_ptr+1` (mod FLUX).
    - The burst counter `bcnt` is cleared and the state goes to SERVE.
  - SERVE, at each edge:
    - If `out_port_full`=1: go to HOLD. No pop, `out_port_write`<=0, `bcnt` frozen.
    - Else if buffer[grant] is non-empty: pop, `out_port_write`<=1, `out_port_dataout`<={grant, head}, `bcnt`++.
      - If `bcnt` reaches BURST, re-arbitrate.
    - Else (buffer[grant] empty, no pop): re-arbitrate. This costs one bubble cycle.
  - HOLD:
    - Stays while `out_port_full`=1, with `out_port_write`=0.
    - On the first edge where `out_port_full`=0, returns to SERVE. No pop occurs on that edge.
  - Re-arbitrate:
    - `rr_ptr`<=grant.
    - The next grant is the first non-empty flux scanning from grant+1, wrapping, and may be grant itself. The non-empty test uses counts after this edge's pop and push.
    - If one is found, `bcnt`<=0 and the state stays SERVE; otherwise the state goes to IDLE.
- Re-arbitrating only at burst end or on empty bounds the wait of any non-empty flux to (FLUX−1)·BURST issued tokens.

## Timing
- Reset values:
  - Outputs: `out_port_write`=0, `out_port_dataout`=0, `grant`=0, `busy`=0, `drop_err`=0, `in_port_full`=0.
  - Internal: all buffers empty, `rr_ptr`=FLUX−1 (so flux 0 wins first), state IDLE.
- Reset asserted mid-burst discards all buffered tokens immediately.
- `in_port_full` is combinational from the registered counts. It rises the cycle after the DEPTH-th push, and falls the cycle after a pop from a full buffer.
- Latency with the system idle: token written at edge k → grant at edge k+1 → pop at edge k+2 → `out_port_write` high during the cycle after edge k+2.
- Steady state: one token per cycle within a burst; a grant change at burst end costs no extra cycle.
- `out_port_full` is sampled at the edge; a token already registered on the output is not retracted.
- A write at the same edge as the pop that empties the flux is counted, so that flux is non-empty for re-arbitration.

## Test plan
- Reset and single token, FLUX=2, DEPTH=4, BURST=2:
  - Hold `rst`=0 for 3 cycles → all outputs 0.
  - Then write {1,8'h04} at edge k → `grant`=1 after edge k+1; `out_port_write`=1 and `out_port_dataout`=9'h104 after edge k+2 only.
- Fairness: write 0x001, 0x002, 0x003 to flux 0 and 0x101, 0x102, 0x103 to flux 1 back-to-back → output order 001, 002, 101, 102, 003, 103.
- Backpressure: assert `out_port_full` for 4 cycles mid-burst → no `out_port_write` while high, `grant` unchanged, and the burst resumes with the remaining token of the same flux.
- Overflow: `out_port_full`=1, write 5 tokens to flux 0 → `in_port_full[0]`=1 after the 4th, the 5th gives a `drop_err` pulse. After release exactly 4 tokens are issued.
- Simultaneous push and pop: stream flux 0 at one token per cycle while it is being served → no token lost, count stable, and flux 1 is still granted after 2 issues.
- Reset mid-operation: drop `rst` with 3 tokens buffered → outputs 0 immediately, and no stale token is issued after release.
